// File: rtl/regfile_wb_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_wb_scoreboard : write-port merge of pipeline/long results + pending
// scoreboard for long-latency destinations.           Rev 1.0
// ---------------------------------------------------------------------------
module regfile_wb_scoreboard #(
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  // decode-side hazard interface
  input  logic        IssueD,
  input  logic        LongD,
  input  logic        RegWriteD,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  input  logic        UsesRs1D,
  input  logic        UsesRs2D,
  output logic        StallD,
  // in-order pipeline writeback request
  input  logic        RegWriteWIn,
  input  logic [4:0]  RdWIn,
  input  logic [31:0] ResultWIn,
  // multi-cycle unit result offer
  input  logic        LongValid,
  input  logic [4:0]  LongRd,
  input  logic [31:0] LongResult,
  output logic        LongReady,
  // regfile write port
  output logic        RegWriteW,
  output logic [4:0]  RdW,
  output logic [31:0] ResultW,
  output logic        ForceBubble
);

  localparam int              CW         = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]   MAX_CNT    = CW'(MAX_OUT);
  localparam logic [7:0]      WAIT_MAX   = 8'hFF;
  localparam logic [7:0]      STARVE_THR = 8'(STARVE_LIMIT);
  localparam logic [31:0]     X0_MASK    = 32'hFFFF_FFFE;

  logic [31:0]   pending;
  logic          buf_full;
  logic [4:0]    buf_rd;
  logic [31:0]   buf_data;
  logic [CW-1:0] count;
  logic [7:0]    wait_cnt;

  logic          pipe_wb;
  logic          commit;
  logic          issue_long;
  logic          capture;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;

  // Hazard check looks only at registered state; a same-cycle commit does not
  // release a stall until the following cycle.
  always_comb begin
    StallD = IssueD && ((UsesRs1D  && pending[Rs1D]) ||
                        (UsesRs2D  && pending[Rs2D]) ||
                        (RegWriteD && pending[RdD])  ||
                        (LongD     && (count == MAX_CNT)));
  end

  assign LongReady   = !buf_full;
  assign capture     = LongValid && !buf_full;
  assign pipe_wb     = RegWriteWIn && (RdWIn != 5'd0);
  assign commit      = buf_full && !pipe_wb;
  assign issue_long  = IssueD && LongD && !StallD;
  assign ForceBubble = (wait_cnt >= STARVE_THR);

  // Pipeline writes to x0 are dead slots, so the buffer may use them.
  always_comb begin
    RegWriteW = RegWriteWIn;
    RdW       = RdWIn;
    ResultW   = ResultWIn;
    if (commit) begin
      RegWriteW = 1'b1;
      RdW       = buf_rd;
      ResultW   = buf_data;
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_long && RegWriteD) set_mask[RdD] = 1'b1;
    if (commit)                  clr_mask[buf_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & X0_MASK;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full <= 1'b0;
      buf_rd   <= '0;
      buf_data <= '0;
    end else if (commit) begin
      buf_full <= 1'b0;
    end else if (capture) begin
      buf_full <= 1'b1;
      buf_rd   <= LongRd;
      buf_data <= LongResult;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({issue_long, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (commit) begin
      wait_cnt <= '0;
    end else if (buf_full && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // A commit without an outstanding op, or an issue past capacity, means the
  // surrounding pipeline broke the handshake.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(commit && !issue_long && (count == '0)))
        else $error("regfile_wb_scoreboard: outstanding count underflow");
      assert (!(issue_long && !commit && (count == MAX_CNT)))
        else $error("regfile_wb_scoreboard: outstanding count overflow");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scoreboard.sv
`default_nettype none
// tb_regfile_wb_scoreboard : directed + random checks against a queue-based
// model of outstanding long-latency ops.
module tb_regfile_wb_scoreboard;

  localparam int MAX_OUT      = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        IssueD, LongD, RegWriteD, UsesRs1D, UsesRs2D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        StallD;
  logic        RegWriteWIn;
  logic [4:0]  RdWIn;
  logic [31:0] ResultWIn;
  logic        LongValid;
  logic [4:0]  LongRd;
  logic [31:0] LongResult;
  logic        LongReady;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        ForceBubble;

  regfile_wb_scoreboard #(.MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .IssueD(IssueD), .LongD(LongD), .RegWriteD(RegWriteD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D), .StallD(StallD),
    .RegWriteWIn(RegWriteWIn), .RdWIn(RdWIn), .ResultWIn(ResultWIn),
    .LongValid(LongValid), .LongRd(LongRd), .LongResult(LongResult),
    .LongReady(LongReady),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .ForceBubble(ForceBubble)
  );

  always #5 clk = ~clk;

  // Model: every issued, uncommitted long op in issue order (its rd, 0 = none).
  // The unit returns in order, so the buffered result always belongs to outq[0].
  int          outq[$];
  bit          bvalid;
  logic [31:0] bdata;
  int          wt;
  bit          last_issue;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic bit pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (outq[i]) if (outq[i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    IssueD = 0; LongD = 0; RegWriteD = 0; UsesRs1D = 0; UsesRs2D = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0;
    RegWriteWIn = 0; RdWIn = 0; ResultWIn = 0;
    LongValid = 0; LongRd = 0; LongResult = 0;
  endtask

  task automatic iss(input bit lng, input bit rw, input int rd,
                     input bit u1, input int r1, input bit u2, input int r2);
    IssueD = 1; LongD = lng; RegWriteD = rw; RdD = 5'(rd);
    UsesRs1D = u1; Rs1D = 5'(r1); UsesRs2D = u2; Rs2D = 5'(r2);
  endtask

  task automatic wb(input bit we, input int rd, input logic [31:0] d);
    RegWriteWIn = we; RdWIn = 5'(rd); ResultWIn = d;
  endtask

  task automatic offer(input logic [31:0] d);
    if (!bvalid && outq.size() > 0) begin
      LongValid = 1; LongRd = 5'(outq[0]); LongResult = d;
    end else begin
      LongValid = 0;
    end
  endtask

  // Called at a falling edge with inputs applied; checks all outputs against
  // the model, then advances the model across the next rising edge.
  task automatic cycle();
    bit e_stall, cmt, b0;
    #1;
    b0      = bvalid;
    e_stall = IssueD && ((UsesRs1D && pend(Rs1D)) || (UsesRs2D && pend(Rs2D)) ||
                         (RegWriteD && pend(RdD)) || (LongD && outq.size() == MAX_OUT));
    cmt     = b0 && !(RegWriteWIn && RdWIn != 5'd0);
    chk("StallD", 32'(StallD), 32'(e_stall));
    chk("LongReady", 32'(LongReady), 32'(!b0));
    chk("ForceBubble", 32'(ForceBubble), 32'(wt >= STARVE_LIMIT));
    chk("RegWriteW", 32'(RegWriteW), cmt ? 32'd1 : 32'(RegWriteWIn));
    chk("RdW", 32'(RdW), cmt ? 32'(outq[0]) : 32'(RdWIn));
    chk("ResultW", ResultW, cmt ? bdata : ResultWIn);
    @(posedge clk);
    if (cmt) begin
      void'(outq.pop_front());
      bvalid = 0;
      wt     = 0;
    end else if (b0 && wt < 255) begin
      wt++;
    end
    if (LongValid && !b0) begin
      bvalid = 1;
      bdata  = LongResult;
    end
    last_issue = IssueD && LongD && !e_stall;
    if (last_issue) outq.push_back(RegWriteD ? int'(RdD) : 0);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && outq.size() > 0; k++) begin
      idle();
      offer($urandom);
      cycle();
    end
  endtask

  initial begin
    bvalid = 0; bdata = 0; wt = 0; last_issue = 0;
    idle();
    reset_n = 0;
    @(negedge clk); #1;
    chk("rst_StallD", 32'(StallD), 32'd0);
    chk("rst_LongReady", 32'(LongReady), 32'd1);
    chk("rst_ForceBubble", 32'(ForceBubble), 32'd0);
    @(negedge clk);
    reset_n = 1;

    // RAW on x7 released by a long result
    idle(); iss(1, 1, 7, 0, 0, 0, 0); cycle();
    idle(); iss(0, 0, 0, 1, 7, 0, 0); offer(32'hDEADBEEF); cycle();
    LongValid = 0; #1;
    chk("raw_stall_at_commit", 32'(StallD), 32'd1);
    chk("raw_commit_data", ResultW, 32'hDEADBEEF);
    cycle();
    #1 chk("raw_release", 32'(StallD), 32'd0);
    cycle();

    // Port conflict: pipeline owns two cycles, buffer x9 commits on the third
    idle(); iss(1, 1, 9, 0, 0, 0, 0); cycle();
    idle(); offer(32'h11); cycle();
    idle(); wb(1, 3, 32'hAAAA); #1 chk("conf_rd_c1", 32'(RdW), 32'd3); cycle();
    #1 chk("conf_rd_c2", 32'(RdW), 32'd3); cycle();
    idle(); #1;
    chk("conf_rd_c3", 32'(RdW), 32'd9);
    chk("conf_data_c3", ResultW, 32'h11);
    cycle();
    iss(0, 0, 0, 1, 9, 0, 0); #1 chk("conf_pending_clear", 32'(StallD), 32'd0); cycle();

    // x0 pipeline writeback yields the port to the buffer
    idle(); iss(1, 1, 4, 0, 0, 0, 0); cycle();
    idle(); offer(32'h22); cycle();
    idle(); wb(1, 0, 32'h55); #1;
    chk("x0_rd", 32'(RdW), 32'd4);
    chk("x0_data", ResultW, 32'h22);
    cycle();

    // Capacity: four in flight block a fifth long issue until one commits
    for (int i = 1; i <= 4; i++) begin idle(); iss(1, 1, i, 0, 0, 0, 0); cycle(); end
    idle(); iss(1, 1, 5, 0, 0, 0, 0); #1 chk("cap_full_stall", 32'(StallD), 32'd1);
    for (int k = 0; k < 20; k++) begin
      idle(); iss(1, 1, 5, 0, 0, 0, 0); offer($urandom); cycle();
      if (last_issue) break;
    end
    chk("cap_accepted", 32'(last_issue), 32'd1);
    drain();

    // Starvation: pipeline hogs the port while x11 waits
    idle(); iss(1, 1, 11, 0, 0, 0, 0); cycle();
    idle(); offer(32'h77); cycle();
    idle(); wb(1, 10, 32'h1234);
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k == 7) chk("starve_below", 32'(ForceBubble), 32'd0);
      if (k == 8) chk("starve_rise", 32'(ForceBubble), 32'd1);
      cycle();
    end
    idle(); #1 chk("starve_commit_rd", 32'(RdW), 32'd11); cycle();
    #1 chk("starve_drop", 32'(ForceBubble), 32'd0); cycle();

    // Random traffic with protocol-respecting result offers
    for (int n = 0; n < 3000; n++) begin
      idle();
      IssueD    = ($urandom % 2) == 0;
      LongD     = ($urandom % 3) == 0;
      RegWriteD = ($urandom % 4) != 0;
      RdD       = 5'($urandom_range(7, 0));
      Rs1D      = 5'($urandom_range(7, 0));
      Rs2D      = 5'($urandom_range(7, 0));
      UsesRs1D  = ($urandom % 2) == 0;
      UsesRs2D  = ($urandom % 2) == 0;
      wb(($urandom % 2) == 0, int'($urandom_range(7, 0)), $urandom);
      if (!bvalid && outq.size() > 0 && ($urandom % 2) == 0) begin
        offer($urandom);
      end else if (bvalid && ($urandom % 4) == 0) begin
        LongValid = 1; LongRd = 5'($urandom); LongResult = $urandom;
      end
      cycle();
    end
    drain();

    // Asynchronous reset mid-run with x5 pending and the buffer full
    idle(); iss(1, 1, 5, 0, 0, 0, 0); cycle();
    idle(); offer(32'h99); cycle();
    idle(); wb(1, 1, 32'h0); cycle();
    wb(1, 1, 32'h0); iss(0, 0, 0, 1, 5, 0, 0); #1;
    chk("pre_rst_stall", 32'(StallD), 32'd1);
    reset_n = 0; #1;
    chk("midrst_StallD", 32'(StallD), 32'd0);
    chk("midrst_LongReady", 32'(LongReady), 32'd1);
    chk("midrst_RegWriteW", 32'(RegWriteW), 32'd1);
    chk("midrst_RdW", 32'(RdW), 32'd1);
    outq.delete(); bvalid = 0; wt = 0;
    @(negedge clk);
    reset_n = 1;
    idle(); iss(0, 0, 0, 1, 5, 0, 0); #1 chk("post_rst_use_x5", 32'(StallD), 32'd0);
    cycle();
    idle(); cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
